diff_link_ctrl: RTL and testbench
=================================

DIFF_LINK_CTRL -- requirements
Module: diff_link_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter BIT_DIV, default 4, CLK cycles per line bit (>=2).
REQ-003 SHALL have parameter TURN_CYC, default 2, bus-turnaround length in bit periods (>=1).
REQ-004 SHALL have parameter RESP_TO, default 16, response timeout in bit periods (>=1).
REQ-005 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have port TX_DATA  input  DATA_W  word to transmit.
REQ-008 SHALL have port TX_VALID  input  1  transmit request.
REQ-009 SHALL have port TX_READY  output  1  controller idle, request accepted when TX_VALID and TX_READY are both high at a CLK edge.
REQ-010 SHALL have port RX_DATA  output  DATA_W  last received word.
REQ-011 SHALL have port RX_VALID  output  1  one-cycle pulse, RX_DATA updated.
REQ-012 SHALL have port TIMEOUT  output  1  one-cycle pulse, no response started.
REQ-013 SHALL have port BUF_I  output  1  drives the differential I/O buffer's I input.
REQ-014 SHALL have port BUF_T  output  1  drives the buffer's T input (1 = released/high-Z).
REQ-015 SHALL have port BUF_O  input  1  from the buffer's O output.

Function
REQ-016 SHALL implement states IDLE, TX_START, TX_BITS, TURN, RX_WAIT, RX_BITS; all outputs registered.
REQ-017 SHALL hold TX_READY=1 only in IDLE; on acceptance, latch TX_DATA and enter TX_START the next cycle.
REQ-018 SHALL in TX_START drive BUF_T=0, BUF_I=1 for BIT_DIV cycles, then TX_BITS.
REQ-019 SHALL in TX_BITS drive BUF_T=0 and the latched bits MSB first, each for BIT_DIV cycles.
REQ-020 SHALL in TURN drive BUF_T=1, BUF_I=0 for TURN_CYC*BIT_DIV cycles, then RX_WAIT.
REQ-021 SHALL in RX_WAIT keep BUF_T=1 and sample BUF_O every cycle; any value other than logic 1 (0, X, Z) counts as 0.
REQ-022 SHALL treat the first cycle with BUF_O=1 in RX_WAIT as start-bit detection and enter RX_BITS.
REQ-023 SHALL sample the MSB data bit BIT_DIV + BIT_DIV/2 (floor) cycles after detection and each further bit every BIT_DIV cycles.
REQ-024 SHALL, on the cycle after the last bit is sampled, update RX_DATA, pulse RX_VALID for one cycle, and be in IDLE with TX_READY=1 in that same cycle.
REQ-025 SHALL, if RX_WAIT lasts RESP_TO*BIT_DIV cycles without detection, pulse TIMEOUT for one cycle, leave RX_DATA unchanged, and return to IDLE in that cycle.
REQ-026 SHALL ignore TX_VALID and TX_DATA changes outside IDLE; no request queuing.
REQ-027 SHALL never drive BUF_T=0 outside TX_START/TX_BITS (parity bit included when enabled).

Reset
REQ-028 SHALL, while RST_N=0, immediately force state IDLE, BUF_T=1, BUF_I=0, TX_READY=1, RX_DATA=0, RX_VALID=0, TIMEOUT=0, PAR_ERR=0, all counters 0.
REQ-029 SHALL discard any transaction in progress at reset without producing RX_VALID or TIMEOUT; operation resumes on the first CLK edge after RST_N rises.

Configuration
REQ-030 SHALL, with macro DIFF_LINK_PARITY_EN defined, append an even-parity bit after the data bits in both directions (one BIT_DIV period each) and add output port PAR_ERR  output  1, valid with RX_VALID, high when received parity mismatches.
REQ-031 SHALL, without DIFF_LINK_PARITY_EN, have no parity bits and no PAR_ERR port.

Verification (DATA_W=8, BIT_DIV=4, TURN_CYC=2, RESP_TO=16, bench models the differential buffer plus a responder on the pair)
REQ-032 SHALL verify: TX 0xA5 -> BUF_T=0 for 36 cycles, BUF_I bits 1,1,0,1,0,0,1,0,1 at 4 cycles each; then BUF_T=1 for 8 cycles; responder sends start+0x3C -> RX_DATA=0x3C, single RX_VALID pulse.
REQ-033 SHALL verify: no responder activity -> TIMEOUT pulse exactly 64 cycles after RX_WAIT entry, RX_VALID stays 0, TX_READY=1.
REQ-034 SHALL verify: TX_VALID held high through a full transaction -> exactly one new acceptance, on the first IDLE cycle after RX_VALID.
REQ-035 SHALL verify: RST_N pulsed low mid TX_BITS -> BUF_T=1 without waiting for CLK, no RX_VALID/TIMEOUT, TX_READY=1 after release.
REQ-036 SHALL verify: BUF_O driven X during RX_WAIT for 10 cycles then valid start+0xFF -> X ignored, RX_DATA=0xFF.
REQ-037 SHALL verify with DIFF_LINK_PARITY_EN: response 0x3C with parity bit 1 -> RX_VALID with PAR_ERR=1; with parity 0 -> PAR_ERR=0.

Source files
------------

// File: rtl/diff_link_ctrl.sv
// diff_link_ctrl: half-duplex master on one differential pair (start bit + MSB-first word).
// Define DIFF_LINK_PARITY_EN to append an even-parity bit each way and expose PAR_ERR.
module diff_link_ctrl #(
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 4,
  parameter int TURN_CYC = 2,
  parameter int RESP_TO  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              TIMEOUT,
`ifdef DIFF_LINK_PARITY_EN
  output logic              PAR_ERR,
`endif
  output logic              BUF_I,
  output logic              BUF_T,
  input  logic              BUF_O
);

`ifdef DIFF_LINK_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int TURN_N  = TURN_CYC * BIT_DIV;
  localparam int WAIT_N  = RESP_TO * BIT_DIV;
  localparam int FIRST_N = BIT_DIV + BIT_DIV / 2;
  localparam int CNT_A   = (TURN_N > WAIT_N) ? TURN_N : WAIT_N;
  localparam int CNT_MAX = (CNT_A > FIRST_N) ? CNT_A : FIRST_N;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = $clog2(NBITS + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] TURN_END = CW'(TURN_N - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(WAIT_N - 1);
  localparam logic [CW-1:0] SAMP_END = CW'(FIRST_N - 1);
  localparam logic [CW-1:0] SAMP_RLD = CW'(FIRST_N - BIT_DIV);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_BITS  = 3'd2;
  localparam logic [2:0] TURN     = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;
  localparam logic [2:0] RX_BITS  = 3'd5;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcnt;
  logic [NBITS-1:0] sh;
  logic [NBITS-1:0] tx_frame;
  logic [NBITS-1:0] rx_next;
  logic             rx_bit;

`ifdef DIFF_LINK_PARITY_EN
  assign tx_frame = {TX_DATA, ^TX_DATA};
`else
  assign tx_frame = TX_DATA;
`endif

  // Only a solid 1 counts; X/Z from an undriven pair reads as 0.
  always_comb begin
    rx_bit = 1'b0;
    if (BUF_O == 1'b1) rx_bit = 1'b1;
  end

  assign rx_next = (sh << 1) | NBITS'(rx_bit);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      bcnt     <= '0;
      sh       <= '0;
      TX_READY <= 1'b1;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      TIMEOUT  <= 1'b0;
      BUF_I    <= 1'b0;
      BUF_T    <= 1'b1;
`ifdef DIFF_LINK_PARITY_EN
      PAR_ERR  <= 1'b0;
`endif
    end else begin
      RX_VALID <= 1'b0;
      TIMEOUT  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (TX_VALID) begin
            sh       <= tx_frame;
            state    <= TX_START;
            TX_READY <= 1'b0;
            BUF_T    <= 1'b0;
            BUF_I    <= 1'b1;
            cnt      <= '0;
          end
        end
        TX_START: begin
          if (cnt == BIT_END) begin
            state <= TX_BITS;
            BUF_I <= sh[NBITS-1];
            sh    <= sh << 1;
            cnt   <= '0;
            bcnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_BITS: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (bcnt == LAST_BIT) begin
              state <= TURN;
              BUF_T <= 1'b1;
              BUF_I <= 1'b0;
            end else begin
              bcnt  <= bcnt + BW'(1);
              BUF_I <= sh[NBITS-1];
              sh    <= sh << 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TURN: begin
          if (cnt == TURN_END) begin
            state <= RX_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          if (rx_bit) begin
            state <= RX_BITS;
            cnt   <= '0;
            bcnt  <= '0;
          end else if (cnt == WAIT_END) begin
            state    <= IDLE;
            TIMEOUT  <= 1'b1;
            TX_READY <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_BITS: begin
          // First sample lands mid data bit, past the start bit.
          if (cnt == SAMP_END) begin
            cnt <= SAMP_RLD;
            sh  <= rx_next;
            if (bcnt == LAST_BIT) begin
              state    <= IDLE;
              TX_READY <= 1'b1;
              RX_VALID <= 1'b1;
              cnt      <= '0;
`ifdef DIFF_LINK_PARITY_EN
              RX_DATA  <= rx_next[NBITS-1:1];
              PAR_ERR  <= ^rx_next;
`else
              RX_DATA  <= rx_next;
`endif
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          TX_READY <= 1'b1;
          BUF_T    <= 1'b1;
          BUF_I    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_link_ctrl.sv
// tb_diff_link_ctrl: buffer + responder model on the pair, vector table,
// hand-written corner sequences and randomized transactions.
module tb_diff_link_ctrl;
  localparam int DW = 8;
  localparam int BD = 4;
  localparam int TC = 2;
  localparam int RT = 16;
`ifdef DIFF_LINK_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int TXC   = BD * (1 + NB);
  localparam int RFC   = BD * (1 + NB);
  localparam int TRN   = TC * BD;
  localparam int WAITC = RT * BD;
  localparam int FIRST = BD + BD / 2;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          timeout;
  logic          buf_i;
  logic          buf_t;
  logic          buf_o;
  logic          line;
`ifdef DIFF_LINK_PARITY_EN
  logic          par_err;
`endif

  // Differential buffer: master wins when enabled, else the responder's level.
  assign buf_o = buf_t ? line : buf_i;

  always #5 clk = ~clk;

  diff_link_ctrl #(
    .DATA_W(DW), .BIT_DIV(BD), .TURN_CYC(TC), .RESP_TO(RT)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .TX_DATA(tx_data),
    .TX_VALID(tx_valid),
    .TX_READY(tx_ready),
    .RX_DATA(rx_data),
    .RX_VALID(rx_valid),
    .TIMEOUT(timeout),
`ifdef DIFF_LINK_PARITY_EN
    .PAR_ERR(par_err),
`endif
    .BUF_I(buf_i),
    .BUF_T(buf_t),
    .BUF_O(buf_o)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            resp_at = NEVER;
  int            x_from = NEVER;
  logic [DW-1:0] resp_w = '0;
  logic          resp_flip = 1'b0;
  logic [DW-1:0] last_rx = '0;

  typedef struct {
    logic [DW-1:0] d;
    int            rd;
    logic [DW-1:0] w;
    logic          ux;
    logic          fl;
    logic          to;
    logic [DW-1:0] rx;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input int idx);
    logic [NB-1:0] f;
`ifdef DIFF_LINK_PARITY_EN
    f = {resp_w, (^resp_w) ^ resp_flip};
`else
    f = resp_w;
`endif
    if (idx == 0) return 1'b1;
    return f[NB-idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= resp_at && cyc < resp_at + RFC)
      line = frame_bit((cyc - resp_at) / BD);
    else if (cyc >= x_from && cyc < resp_at)
      line = 1'bx;
    else
      line = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (tx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: TX_READY=%b expected 1 within 300 cycles",
               tx_ready);
    end
  endtask

  task automatic run_txn(input logic [DW-1:0] d, input int rd,
                         input logic [DW-1:0] w, input logic use_x,
                         input logic flip, input logic exp_to,
                         input logic [DW-1:0] exp_rx);
    logic [63:0]   at, ai, et, ei;
    logic [NB-1:0] tf;
    logic [DW-1:0] data_at;
    logic          rdy_at;
    logic          perr_at;
    int            ew, rx_j, to_j, rx_n, to_n, drv, exp_j, last;
`ifdef DIFF_LINK_PARITY_EN
    tf = {d, ^d};
`else
    tf = d;
`endif
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid  = 1'b0;
    tx_data   = DW'($urandom);
    ew        = cyc + TXC + TRN;
    resp_w    = w;
    resp_flip = flip;
    resp_at   = ew + rd;
    x_from    = use_x ? ew : NEVER;
    at = '0; ai = '0; et = '0; ei = '0;
    for (int k = 0; k < TXC + TRN; k++) begin
      at[k] = buf_t;
      ai[k] = buf_i;
      et[k] = (k >= TXC);
      if (k < BD) ei[k] = 1'b1;
      else if (k < TXC) ei[k] = tf[NB - k / BD];
      else ei[k] = 1'b0;
      tick();
    end
    rx_j = -1; to_j = -1; rx_n = 0; to_n = 0; drv = 0;
    data_at = '0; rdy_at = 1'b0; perr_at = 1'b0;
    for (int j = 0; j < WAITC + RFC + 20; j++) begin
      if (buf_t !== 1'b1) drv++;
      if (rx_valid) begin
        rx_n++;
        if (rx_j < 0) begin
          rx_j = j; data_at = rx_data; rdy_at = tx_ready;
`ifdef DIFF_LINK_PARITY_EN
          perr_at = par_err;
`endif
        end
      end
      if (timeout) begin
        to_n++;
        if (to_j < 0) begin
          to_j = j; data_at = rx_data; rdy_at = tx_ready;
        end
      end
      last = (rx_j > to_j) ? rx_j : to_j;
      if (last >= 0 && j >= last + 2) break;
      tick();
    end
    resp_at = NEVER;
    x_from  = NEVER;
    exp_j = exp_to ? WAITC : rd + 1 + FIRST + (NB - 1) * BD;
    check("tx_wave_t", at, et);
    check("tx_wave_i", ai, ei);
    check("rx_phase_drive", 64'(drv), 64'd0);
    if (exp_to) begin
      check("timeout_at", 64'(to_j), 64'(exp_j));
      check("timeout_pulses", 64'(to_n), 64'd1);
      check("rx_valid_pulses", 64'(rx_n), 64'd0);
    end else begin
      check("rx_valid_at", 64'(rx_j), 64'(exp_j));
      check("rx_valid_pulses", 64'(rx_n), 64'd1);
      check("timeout_pulses", 64'(to_n), 64'd0);
`ifdef DIFF_LINK_PARITY_EN
      check("par_err", 64'(perr_at), 64'(flip));
`else
      check("par_err_none", 64'(perr_at), 64'd0);
`endif
    end
    check("rx_data", 64'(data_at), 64'(exp_rx));
    check("ready_at_end", 64'(rdy_at), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] d, w;
    int            rd, acc, acc_j, rx_n, rx_j, to_n;
    logic          ux, fl, to;

    tbl[0] = '{8'hA5, 3,   8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[1] = '{8'h00, 200, 8'h11, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[2] = '{8'h5A, 10,  8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};
    tbl[3] = '{8'hFF, 0,   8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{8'h81, 63,  8'h7E, 1'b0, 1'b0, 1'b0, 8'h7E};
    tbl[5] = '{8'hC3, 64,  8'h55, 1'b0, 1'b0, 1'b1, 8'h7E};
    tbl[6] = '{8'h12, 4,   8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[7] = '{8'h34, 7,   8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};

    tx_data  = '0;
    tx_valid = 1'b0;
    line     = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_state",
          64'({tx_ready, buf_t, buf_i, rx_valid, timeout, rx_data}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}));
`ifdef DIFF_LINK_PARITY_EN
    check("rst_par_err", 64'(par_err), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].d, tbl[i].rd, tbl[i].w, tbl[i].ux, tbl[i].fl,
              tbl[i].to, tbl[i].rx);
    last_rx = 8'h3C;

    // TX_VALID held through a whole transaction
    wait_ready();
    tx_data   = 8'h96;
    tx_valid  = 1'b1;
    resp_w    = 8'h69;
    resp_flip = 1'b0;
    resp_at   = cyc + 1 + TXC + TRN + 5;
    acc = 0; acc_j = -1; rx_n = 0; rx_j = -1;
    for (int j = 0; j < 230; j++) begin
      if (tx_valid && tx_ready) begin
        acc++;
        acc_j = j;
      end
      if (rx_valid) begin
        rx_n++;
        rx_j = j;
      end
      tick();
      if (acc == 2) tx_valid = 1'b0;
      else tx_data = DW'($urandom);
    end
    resp_at = NEVER;
    check("hold_accepts", 64'(acc), 64'd2);
    check("hold_accept_at_rx", 64'(acc_j), 64'(rx_j));
    check("hold_rx_pulses", 64'(rx_n), 64'd1);
    check("hold_rx_data", 64'(rx_data), 64'h69);
    last_rx = 8'h69;

    for (int i = 0; i < 16; i++) begin
      d  = DW'($urandom);
      w  = DW'($urandom);
      rd = $urandom_range(0, 80);
      ux = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 1));
      to = (rd >= WAITC);
      run_txn(d, rd, w, ux, fl, to, to ? last_rx : w);
      if (!to) last_rx = w;
    end

    // Reset pulse in the middle of TX_BITS
    wait_ready();
    tx_data  = 8'hC6;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    check("pre_rst_drive", 64'(buf_t), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_buf_t", 64'(buf_t), 64'd1);
    check("rst_async_buf_i", 64'(buf_i), 64'd0);
    check("rst_async_ready", 64'(tx_ready), 64'd1);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    rx_n = 0; to_n = 0;
    tick();
    check("post_rst_ready", 64'(tx_ready), 64'd1);
    check("post_rst_rx_data", 64'(rx_data), 64'd0);
    for (int j = 0; j < 130; j++) begin
      if (rx_valid) rx_n++;
      if (timeout) to_n++;
      tick();
    end
    check("post_rst_rx_pulses", 64'(rx_n), 64'd0);
    check("post_rst_timeouts", 64'(to_n), 64'd0);
    check("post_rst_idle", 64'({tx_ready, buf_t}), 64'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
